bridge_seq_ctrl: RTL and testbench



---
 rtl/bridge_pkg.sv | 64 ++++++
 rtl/gate_deadtime.sv | 59 +++++
 rtl/bridge_seq_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_bridge_seq_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and the gate-pattern decode for the bridge sequencer.
package bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_ARM,
    DIS0,
    DIS1,
    DIS2,
    DIS3,
    ERROR
  } proto_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRECHARGE,
    S_SETTLE
  } start_state_t;

  typedef enum logic [2:0] {
    OFF,
    PLUS,
    MINUS,
    BALP,
    BALN,
    DISB
  } gate_pat_t;

  // Physical drive levels and indicator bits for one gate pattern.
  typedef struct packed {
    logic [3:0] top;
    logic [3:0] bot;
    logic       plus;
    logic       minus;
    logic       pause_p;
    logic       pause_n;
  } gate_drive_t;

  // Command codes on bus_data.
  localparam logic [2:0] CMD_OFF      = 3'd0;
  localparam logic [2:0] CMD_PLUS     = 3'd1;
  localparam logic [2:0] CMD_MINUS    = 3'd2;
  localparam logic [2:0] CMD_BALP     = 3'd3;
  localparam logic [2:0] CMD_BALN     = 3'd4;
  localparam logic [2:0] CMD_START    = 3'd5;
  localparam logic [2:0] CMD_SHUTDOWN = 3'd6;
  localparam logic [2:0] CMD_DIS      = 3'd7;

  // Map a pattern to its top/bottom drives and indicator flags.
  function automatic gate_drive_t pat_drive(input gate_pat_t p);
    gate_drive_t d;
    d = '0;
    case (p)
      PLUS:    begin d.top = 4'b0001; d.bot = 4'b0010; d.plus    = 1'b1; end
      MINUS:   begin d.top = 4'b0010; d.bot = 4'b0001; d.minus   = 1'b1; end
      BALP:    begin d.top = 4'b0100; d.bot = 4'b1000; d.pause_p = 1'b1; end
      BALN:    begin d.top = 4'b1000; d.bot = 4'b0100; d.pause_n = 1'b1; end
      DISB:    begin d.top = 4'b0100; d.bot = 4'b1000; d.plus    = 1'b1; end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/gate_deadtime.sv
// Dead-time enforcement between gate patterns: a non-OFF pattern is only
// applied after DEADTIME_CYC consecutive all-off cycles; OFF applies at once.
module gate_deadtime
  import bridge_pkg::*;
#(
  parameter int DEADTIME_CYC = 50
) (
  input  logic      clk,
  input  logic      rst,
  input  gate_pat_t req_pat,
  input  logic      force_off,
  output gate_pat_t applied_pat,
  output logic      busy
);

  localparam int CW = $clog2(DEADTIME_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEADTIME_CYC);

  gate_pat_t      applied_q, applied_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;

  // Register the applied pattern, the all-off run length and the busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      applied_q <= OFF;
      cnt_q     <= CNT_MAX;
      busy_q    <= 1'b0;
    end else begin
      applied_q <= applied_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  // Decide what reaches the gates this cycle. A change between two non-OFF
  // patterns always passes through OFF first, which restarts the count.
  // cnt counts OFF cycles including the one being entered, so a pattern is
  // held off for exactly DEADTIME_CYC visible cycles.
  always_comb begin
    applied_d = applied_q;
    if (force_off || req_pat == OFF) begin
      applied_d = OFF;
    end else if (req_pat != applied_q) begin
      if (applied_q != OFF)       applied_d = OFF;
      else if (cnt_q == CNT_MAX)  applied_d = req_pat;
      else                        applied_d = OFF;
    end

    cnt_d = '0;
    if (applied_d == OFF) cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);

    busy_d = (req_pat != OFF) && !force_off && (applied_d != req_pat);
  end

  assign applied_pat = applied_q;
  assign busy        = busy_q;

endmodule

// File: rtl/bridge_seq_ctrl.sv
// Bridge sequencer: decodes strobed 3-bit commands, runs the precharge/settle
// start sequence and the discharge chain, latches faults and drives the gates
// through the dead-time stage.
module bridge_seq_ctrl
  import bridge_pkg::*;
#(
  parameter int FREQ          = 50000000,
  parameter int T_PRECHARGE_S = 15,
  parameter int T_SETTLE_S    = 1,
  parameter int DEADTIME_CYC  = 50,
  parameter int NUM_ERR       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bus_strobe,
  input  logic [2:0]         bus_data,
  input  logic [NUM_ERR-1:0] err_in,
  input  logic               err_clear,
  output logic [3:0]         o_top,
  output logic [3:0]         o_bot,
  output logic               o_plus,
  output logic               o_minus,
  output logic               o_pause_p,
  output logic               o_pause_n,
  output logic               o_st,
  output logic               o_ch,
  output logic               o_fan,
  output logic               o_break,
  output logic [NUM_ERR-1:0] err_latched,
  output logic               fault,
  output logic               ready,
  output logic               deadtime_busy
);

  localparam longint LOAD_PRE = longint'(FREQ) * longint'(T_PRECHARGE_S);
  localparam longint LOAD_SET = longint'(FREQ) * longint'(T_SETTLE_S);
  localparam longint MAX_LOAD = (LOAD_PRE > LOAD_SET) ? LOAD_PRE : LOAD_SET;
  localparam int     TW       = (MAX_LOAD > 0) ? $clog2(MAX_LOAD + 1) : 1;
  localparam logic [TW-1:0] PRE_T = TW'(LOAD_PRE);
  localparam logic [TW-1:0] SET_T = TW'(LOAD_SET);

  proto_state_t       state_q, state_d;
  start_state_t       start_q, start_d;
  logic [TW-1:0]      timer_q, timer_d;
  gate_pat_t          req_pat_q, req_pat_d;
  logic               strobe_q;
  logic               st_q, st_d, ch_q, ch_d, fan_q, fan_d;
  logic               brk_q, brk_d, fault_q, fault_d;
  logic [NUM_ERR-1:0] err_latched_q, err_latched_d;

  logic        cmd_fire, err_any, start_active, run_ok, timer_last;
  gate_pat_t   applied_pat;
  gate_drive_t drive;

  assign cmd_fire     = strobe_q && !bus_strobe;
  assign err_any      = |err_in;
  assign start_active = (start_q != S_IDLE);
  assign run_ok       = st_q && !ch_q && !start_active;
  assign timer_last   = (timer_q <= TW'(1));

  // State register for the protocol FSM and all sequencer flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      start_q       <= S_IDLE;
      timer_q       <= '0;
      req_pat_q     <= OFF;
      strobe_q      <= 1'b0;
      st_q          <= 1'b0;
      ch_q          <= 1'b0;
      fan_q         <= 1'b0;
      brk_q         <= 1'b0;
      fault_q       <= 1'b0;
      err_latched_q <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      timer_q       <= timer_d;
      req_pat_q     <= req_pat_d;
      strobe_q      <= bus_strobe;
      st_q          <= st_d;
      ch_q          <= ch_d;
      fan_q         <= fan_d;
      brk_q         <= brk_d;
      fault_q       <= fault_d;
      err_latched_q <= err_latched_d;
    end
  end

  // Next protocol state: a fault overrides everything, ERROR only leaves
  // through a clean err_clear, otherwise commands walk the decode chain.
  always_comb begin
    state_d = state_q;
    if (err_any) begin
      state_d = ERROR;
    end else if (state_q == ERROR) begin
      if (err_clear) state_d = IDLE;
    end else if (cmd_fire) begin
      case (state_q)
        IDLE: begin
          if (bus_data == CMD_START && !start_active) state_d = START_ARM;
          if (bus_data == CMD_DIS   && !start_active) state_d = DIS0;
        end
        DIS0:    state_d = (bus_data == CMD_OFF) ? DIS1 : IDLE;
        DIS1:    state_d = (bus_data == CMD_DIS) ? DIS2 : IDLE;
        DIS2:    state_d = (bus_data == CMD_OFF) ? DIS3 : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Sequencer actions. Ordering sets priority: timer expiry first, then
  // command effects (so shutdown beats expiry), then fault clear, then fault.
  always_comb begin
    start_d       = start_q;
    timer_d       = timer_q;
    req_pat_d     = req_pat_q;
    st_d          = st_q;
    ch_d          = ch_q;
    fan_d         = fan_q;
    brk_d         = brk_q;
    fault_d       = fault_q;
    err_latched_d = err_latched_q | err_in;

    case (start_q)
      S_PRECHARGE: begin
        if (timer_last) begin
          st_d    = 1'b1;
          timer_d = SET_T;
          start_d = S_SETTLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_SETTLE: begin
        if (timer_last) begin
          ch_d    = 1'b0;
          timer_d = '0;
          start_d = S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: ;
    endcase

    if (cmd_fire && state_q != ERROR) begin
      case (state_q)
        IDLE: begin
          case (bus_data)
            CMD_OFF:   req_pat_d = OFF;
            CMD_PLUS:  if (run_ok) req_pat_d = PLUS;
            CMD_MINUS: if (run_ok) req_pat_d = MINUS;
            CMD_BALP:  if (run_ok) req_pat_d = BALP;
            CMD_BALN:  if (run_ok) req_pat_d = BALN;
            CMD_SHUTDOWN: begin
              start_d   = S_IDLE;
              timer_d   = '0;
              req_pat_d = OFF;
              st_d      = 1'b0;
              ch_d      = 1'b0;
              fan_d     = 1'b0;
            end
            default: ;
          endcase
        end
        START_ARM: begin
          if (bus_data == CMD_OFF) begin
            req_pat_d = OFF;
            fan_d     = 1'b1;
            st_d      = 1'b0;
            ch_d      = 1'b1;
            timer_d   = PRE_T;
            start_d   = S_PRECHARGE;
          end
        end
        DIS3: begin
          if (!st_q && !ch_q) begin
            if (bus_data == CMD_PLUS) req_pat_d = PLUS;
            if (bus_data == CMD_BALP) req_pat_d = DISB;
          end
        end
        default: ;
      endcase
    end

    if (state_q == ERROR && err_clear && !err_any) begin
      err_latched_d = '0;
      brk_d         = 1'b0;
      fault_d       = 1'b0;
    end

    if (err_any) begin
      fault_d   = 1'b1;
      brk_d     = 1'b1;
      fan_d     = 1'b1;
      st_d      = 1'b0;
      ch_d      = 1'b0;
      req_pat_d = OFF;
      start_d   = S_IDLE;
      timer_d   = '0;
    end
  end

  gate_deadtime #(
    .DEADTIME_CYC(DEADTIME_CYC)
  ) u_deadtime (
    .clk        (clk),
    .rst        (rst),
    .req_pat    (req_pat_d),
    .force_off  (err_any),
    .applied_pat(applied_pat),
    .busy       (deadtime_busy)
  );

  assign drive       = pat_drive(applied_pat);
  assign o_top       = drive.top;
  assign o_bot       = drive.bot;
  assign o_plus      = drive.plus;
  assign o_minus     = drive.minus;
  assign o_pause_p   = drive.pause_p;
  assign o_pause_n   = drive.pause_n;
  assign o_st        = st_q;
  assign o_ch        = ch_q;
  assign o_fan       = fan_q;
  assign o_break     = brk_q;
  assign fault       = fault_q;
  assign err_latched = err_latched_q;
  assign ready       = (state_q == IDLE);

endmodule

// File: tb/tb_bridge_seq_ctrl.sv
// Directed bench for bridge_seq_ctrl with small timer and dead-time values.
module tb_bridge_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bus_strobe = 1'b0;
  logic [2:0] bus_data = 3'd0;
  logic [7:0] err_in = 8'h00;
  logic       err_clear = 1'b0;
  logic [3:0] o_top, o_bot;
  logic       o_plus, o_minus, o_pause_p, o_pause_n;
  logic       o_st, o_ch, o_fan, o_break;
  logic [7:0] err_latched;
  logic       fault, ready, deadtime_busy;

  int checks = 0;
  int errors = 0;

  // gate_v = {top, bot, plus, minus, pause_p, pause_n}
  // ctl_v  = {st, ch, fan, break, fault, ready, deadtime_busy}
  logic [11:0] gate_v;
  logic [6:0]  ctl_v;
  assign gate_v = {o_top, o_bot, o_plus, o_minus, o_pause_p, o_pause_n};
  assign ctl_v  = {o_st, o_ch, o_fan, o_break, fault, ready, deadtime_busy};

  bridge_seq_ctrl #(
    .FREQ(10), .T_PRECHARGE_S(2), .T_SETTLE_S(1), .DEADTIME_CYC(4), .NUM_ERR(8)
  ) dut (
    .clk(clk), .rst(rst), .bus_strobe(bus_strobe), .bus_data(bus_data),
    .err_in(err_in), .err_clear(err_clear),
    .o_top(o_top), .o_bot(o_bot), .o_plus(o_plus), .o_minus(o_minus),
    .o_pause_p(o_pause_p), .o_pause_n(o_pause_n),
    .o_st(o_st), .o_ch(o_ch), .o_fan(o_fan), .o_break(o_break),
    .err_latched(err_latched), .fault(fault), .ready(ready),
    .deadtime_busy(deadtime_busy)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks: inputs change 1 ns after the rising edge.
  task automatic send_cmd(input logic [2:0] c);
    bus_data = c;
    bus_strobe = 1'b1;
    @(posedge clk); #1;
    bus_strobe = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pulse_err(input logic [7:0] e, input logic clr);
    err_in = e;
    err_clear = clr;
    @(posedge clk); #1;
    err_in = 8'h00;
    err_clear = 1'b0;
  endtask

  task automatic test_reset();
    pulse_rst();
    checks++; if (gate_v !== 12'h000) begin errors++; $display("FAIL reset_gate: got %h want %h", gate_v, 12'h000); end
    checks++; if (ctl_v !== 7'b0000010) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl_v, 7'b0000010); end
    checks++; if (err_latched !== 8'h00) begin errors++; $display("FAIL reset_err: got %h want %h", err_latched, 8'h00); end
  endtask

  task automatic test_start();
    send_cmd(3'd5);
    checks++; if (ctl_v !== 7'b0000000) begin errors++; $display("FAIL arm_ctl: got %b want %b", ctl_v, 7'b0000000); end
    send_cmd(3'd0);
    checks++; if (ctl_v !== 7'b0110010) begin errors++; $display("FAIL start_ctl: got %b want %b", ctl_v, 7'b0110010); end
    repeat (19) @(posedge clk); #1;
    checks++; if (ctl_v !== 7'b0110010) begin errors++; $display("FAIL pre19_ctl: got %b want %b", ctl_v, 7'b0110010); end
    @(posedge clk); #1;
    checks++; if (ctl_v !== 7'b1110010) begin errors++; $display("FAIL pre20_ctl: got %b want %b", ctl_v, 7'b1110010); end
    repeat (9) @(posedge clk); #1;
    checks++; if (ctl_v !== 7'b1110010) begin errors++; $display("FAIL set9_ctl: got %b want %b", ctl_v, 7'b1110010); end
    @(posedge clk); #1;
    checks++; if (ctl_v !== 7'b1010010) begin errors++; $display("FAIL set10_ctl: got %b want %b", ctl_v, 7'b1010010); end
  endtask

  task automatic test_run_patterns();
    send_cmd(3'd1);
    checks++; if (gate_v !== 12'h128) begin errors++; $display("FAIL plus_gate: got %h want %h", gate_v, 12'h128); end
    send_cmd(3'd2);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) begin @(posedge clk); #1; end
      checks++; if ({gate_v, ctl_v} !== {12'h000, 7'b1010011}) begin errors++; $display("FAIL dt_minus_%0d: got %h/%b want 000/1010011", i, gate_v, ctl_v); end
    end
    @(posedge clk); #1;
    checks++; if ({gate_v, ctl_v} !== {12'h214, 7'b1010010}) begin errors++; $display("FAIL minus_gate: got %h/%b want 214/1010010", gate_v, ctl_v); end
    // Pending PLUS replaced by BALN while dead time runs.
    send_cmd(3'd1);
    send_cmd(3'd4);
    checks++; if ({gate_v, ctl_v} !== {12'h000, 7'b1010011}) begin errors++; $display("FAIL dt_repl_a: got %h/%b want 000/1010011", gate_v, ctl_v); end
    @(posedge clk); #1;
    checks++; if ({gate_v, ctl_v} !== {12'h000, 7'b1010011}) begin errors++; $display("FAIL dt_repl_b: got %h/%b want 000/1010011", gate_v, ctl_v); end
    @(posedge clk); #1;
    checks++; if ({gate_v, ctl_v} !== {12'h841, 7'b1010010}) begin errors++; $display("FAIL baln_gate: got %h/%b want 841/1010010", gate_v, ctl_v); end
    send_cmd(3'd0);
    checks++; if (gate_v !== 12'h000) begin errors++; $display("FAIL off_gate: got %h want %h", gate_v, 12'h000); end
    send_cmd(3'd6);
    checks++; if ({gate_v, ctl_v} !== {12'h000, 7'b0000010}) begin errors++; $display("FAIL shutdown: got %h/%b want 000/0000010", gate_v, ctl_v); end
  endtask

  task automatic test_discharge();
    send_cmd(3'd1);
    checks++; if (gate_v !== 12'h000) begin errors++; $display("FAIL plus_no_run: got %h want %h", gate_v, 12'h000); end
    send_cmd(3'd7);
    checks++; if (ctl_v !== 7'b0000000) begin errors++; $display("FAIL dis0_ready: got %b want %b", ctl_v, 7'b0000000); end
    send_cmd(3'd0);
    send_cmd(3'd7);
    send_cmd(3'd0);
    send_cmd(3'd3);
    checks++; if ({gate_v, ctl_v} !== {12'h488, 7'b0000010}) begin errors++; $display("FAIL disb_gate: got %h/%b want 488/0000010", gate_v, ctl_v); end
    send_cmd(3'd0);
  endtask

  task automatic test_fault();
    send_cmd(3'd5);
    send_cmd(3'd0);
    repeat (3) @(posedge clk); #1;
    pulse_err(8'h04, 1'b0);
    checks++; if ({gate_v, ctl_v} !== {12'h000, 7'b0011100}) begin errors++; $display("FAIL fault_ctl: got %h/%b want 000/0011100", gate_v, ctl_v); end
    checks++; if (err_latched !== 8'h04) begin errors++; $display("FAIL fault_latch: got %h want %h", err_latched, 8'h04); end
    send_cmd(3'd5);
    send_cmd(3'd0);
    checks++; if (ctl_v !== 7'b0011100) begin errors++; $display("FAIL fault_ignore: got %b want %b", ctl_v, 7'b0011100); end
    repeat (25) @(posedge clk); #1;
    checks++; if (ctl_v !== 7'b0011100) begin errors++; $display("FAIL fault_abort: got %b want %b", ctl_v, 7'b0011100); end
    pulse_err(8'h00, 1'b1);
    checks++; if (ctl_v !== 7'b0010010) begin errors++; $display("FAIL clear_ctl: got %b want %b", ctl_v, 7'b0010010); end
    checks++; if (err_latched !== 8'h00) begin errors++; $display("FAIL clear_latch: got %h want %h", err_latched, 8'h00); end
  endtask

  task automatic test_clear_race();
    pulse_err(8'h02, 1'b0);
    checks++; if (err_latched !== 8'h02) begin errors++; $display("FAIL race_pre: got %h want %h", err_latched, 8'h02); end
    pulse_err(8'h01, 1'b1);
    checks++; if ({ctl_v, err_latched} !== {7'b0011100, 8'h03}) begin errors++; $display("FAIL race_err_wins: got %b/%h want 0011100/03", ctl_v, err_latched); end
    pulse_err(8'h00, 1'b1);
    checks++; if ({ctl_v, err_latched} !== {7'b0010010, 8'h00}) begin errors++; $display("FAIL race_clear: got %b/%h want 0010010/00", ctl_v, err_latched); end
    pulse_err(8'h00, 1'b1);
    checks++; if (ctl_v !== 7'b0010010) begin errors++; $display("FAIL clear_idle: got %b want %b", ctl_v, 7'b0010010); end
  endtask

  task automatic test_reset_mid();
    send_cmd(3'd5);
    send_cmd(3'd0);
    repeat (5) @(posedge clk); #1;
    pulse_rst();
    checks++; if ({gate_v, ctl_v, err_latched} !== {12'h000, 7'b0000010, 8'h00}) begin errors++; $display("FAIL rst_pre: got %h/%b/%h want 000/0000010/00", gate_v, ctl_v, err_latched); end
    repeat (25) @(posedge clk); #1;
    checks++; if (ctl_v !== 7'b0000010) begin errors++; $display("FAIL rst_pre_abort: got %b want %b", ctl_v, 7'b0000010); end
    send_cmd(3'd5);
    send_cmd(3'd0);
    repeat (30) @(posedge clk); #1;
    checks++; if (ctl_v !== 7'b1010010) begin errors++; $display("FAIL run2_ctl: got %b want %b", ctl_v, 7'b1010010); end
    send_cmd(3'd1);
    send_cmd(3'd2);
    checks++; if ({gate_v, ctl_v} !== {12'h000, 7'b1010011}) begin errors++; $display("FAIL rst_dt_pre: got %h/%b want 000/1010011", gate_v, ctl_v); end
    pulse_rst();
    checks++; if ({gate_v, ctl_v} !== {12'h000, 7'b0000010}) begin errors++; $display("FAIL rst_dt: got %h/%b want 000/0000010", gate_v, ctl_v); end
    send_cmd(3'd7);
    send_cmd(3'd0);
    send_cmd(3'd7);
    send_cmd(3'd0);
    send_cmd(3'd1);
    checks++; if ({gate_v, ctl_v} !== {12'h128, 7'b0000010}) begin errors++; $display("FAIL rst_plus: got %h/%b want 128/0000010", gate_v, ctl_v); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_run_patterns();
    test_discharge();
    test_fault();
    test_clear_race();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
